// File: rtl/oled_stream_pkg.sv
// rtl/oled_stream_pkg.sv - shared encodings and constants for the OLED frame streamer
package oled_stream_pkg;
    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_START = 3'd1;
    localparam state_t S_BIT   = 3'd2;
    localparam state_t S_ACK   = 3'd3;
    localparam state_t S_STOP  = 3'd4;
    localparam state_t S_GAP   = 3'd5;

    localparam logic [7:0] OLED_CTRL_DATA   = 8'h40;
    localparam logic       I2C_WRITE        = 1'b0;
    localparam int         FRAME_BYTES      = 1024;
    localparam int         QUARTERS_PER_BIT = 4;
endpackage

// File: rtl/oled_frame_streamer_if.sv
// rtl/oled_frame_streamer_if.sv - pixel fetch interface between streamer and text engine
interface oled_frame_streamer_if;
    logic [9:0] pixel_address;
    logic [7:0] pixel_data;

    modport master (output pixel_address, input pixel_data);
    modport slave  (input pixel_address, output pixel_data);
endinterface

// File: rtl/oled_frame_streamer_i2c_quarter_tick.sv
// rtl/oled_frame_streamer_i2c_quarter_tick.sv - divider pulsing qtick once every CLK_DIV clocks
module i2c_quarter_tick #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic clear_n,
    output logic qtick
);
    localparam int W = $clog2(CLK_DIV);

    logic [W-1:0] cnt;

    assign qtick = (cnt == W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!clear_n || qtick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/oled_frame_streamer.sv
// rtl/oled_frame_streamer.sv - I2C master streaming 1024-byte GDDRAM frames; OLED_ACK_CHECK_EN enables NACK abort
module oled_frame_streamer
    import oled_stream_pkg::*;
#(
    parameter int         CLK_DIV      = 25,
    parameter logic [6:0] I2C_ADDR     = 7'h3C,
    parameter logic [7:0] CTRL_BYTE    = OLED_CTRL_DATA,
    parameter int         NUM_BYTES    = FRAME_BYTES,
    parameter int         GAP_QUARTERS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    oled_frame_streamer_if.master        pix,
    output logic                         scl_o,
    output logic                         sda_oe,
    input  logic                         sda_i,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         nack_error
);
`ifdef OLED_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif

    localparam int          GW        = (GAP_QUARTERS > 1) ? $clog2(GAP_QUARTERS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_QUARTERS - 1);
    localparam logic [10:0] LAST_BYTE = 11'(NUM_BYTES + 1);
    localparam logic [9:0]  ADDR_LAST = 10'(NUM_BYTES - 1);
    localparam logic [1:0]  Q_LAST    = 2'(QUARTERS_PER_BIT - 1);

    state_t        state, state_nx;
    logic          qtick;
    logic [1:0]    q;
    logic [2:0]    bit_idx;
    logic [10:0]   byte_cnt;
    logic [7:0]    shift;
    logic [9:0]    addr;
    logic [GW-1:0] gap_cnt;
    logic          ack_bad;
    logic          nack_q;
    logic          nack_now;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .clear_n (reset),
        .qtick   (qtick)
    );

    assign nack_now          = ACK_CHECK && ack_bad;
    assign nack_error        = nack_q;
    assign pix.pixel_address = addr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (qtick) begin
            case (state)
                S_IDLE:  if (enable) state_nx = S_START;
                S_START: if (q == 2'd1) state_nx = S_BIT;
                S_BIT:   if (q == Q_LAST && bit_idx == 3'd7) state_nx = S_ACK;
                S_ACK:   if (q == Q_LAST) state_nx = (byte_cnt == LAST_BYTE || nack_now) ? S_STOP : S_BIT;
                S_STOP:  if (q == 2'd2) state_nx = S_GAP;
                S_GAP:   if (gap_cnt == GAP_LAST) state_nx = enable ? S_START : S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // SCL is high in the second half of every bit/ACK slot, hence q[1].
    always_comb begin
        scl_o      = 1'b1;
        sda_oe     = 1'b0;
        frame_done = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_START: begin
                sda_oe = 1'b1;
                scl_o  = (q == 2'd0);
            end
            S_BIT: begin
                sda_oe = ~shift[7];
                scl_o  = q[1];
            end
            S_ACK:   scl_o = q[1];
            S_STOP: begin
                scl_o      = (q != 2'd0);
                sda_oe     = (q != 2'd2);
                frame_done = qtick && (q == 2'd2) && !nack_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q        <= '0;
            bit_idx  <= '0;
            byte_cnt <= '0;
            shift    <= '0;
            addr     <= '0;
            gap_cnt  <= '0;
            ack_bad  <= 1'b0;
            nack_q   <= 1'b0;
        end else if (qtick) begin
            q       <= (state_nx != state) ? 2'd0 : q + 2'd1;
            gap_cnt <= (state == S_GAP && state_nx == S_GAP) ? gap_cnt + GW'(1) : '0;
            if (state_nx == S_START && state != S_START) begin
                nack_q <= 1'b0;
            end
            case (state)
                S_START: if (q == 2'd1) begin
                    shift    <= {I2C_ADDR, I2C_WRITE};
                    byte_cnt <= '0;
                    bit_idx  <= '0;
                end
                S_BIT: if (q == Q_LAST) begin
                    shift   <= {shift[6:0], 1'b0};
                    bit_idx <= bit_idx + 3'd1;
                end
                S_ACK: begin
                    if (q == 2'd2) begin
                        ack_bad <= sda_i;
                    end
                    if (q == Q_LAST) begin
                        if (state_nx == S_BIT) begin
                            byte_cnt <= byte_cnt + 11'd1;
                            if (byte_cnt == 11'd0) begin
                                shift <= CTRL_BYTE;
                            end else begin
                                shift <= pix.pixel_data;
                                addr  <= (addr == ADDR_LAST) ? 10'd0 : addr + 10'd1;
                            end
                        end else if (nack_now) begin
                            nack_q <= 1'b1;
                            addr   <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_oled_frame_streamer.sv
// tb/tb_oled_frame_streamer.sv - randomized-data bench with I2C slave monitor and frame model
module tb_oled_frame_streamer;
    localparam int CLK_DIV = 2;
    localparam int NB      = 24;
    localparam int GAPQ    = 4;
    localparam int BUDGET  = 5000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic scl_o, sda_oe, busy, frame_done, nack_error;
    logic pull = 1'b0;
    logic sda_line;
    logic [7:0] salt;

    oled_frame_streamer_if pif();

    assign sda_line = ~sda_oe & ~pull;

    oled_frame_streamer #(
        .CLK_DIV      (CLK_DIV),
        .NUM_BYTES    (NB),
        .GAP_QUARTERS (GAPQ)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pix        (pif),
        .scl_o      (scl_o),
        .sda_oe     (sda_oe),
        .sda_i      (sda_line),
        .busy       (busy),
        .frame_done (frame_done),
        .nack_error (nack_error)
    );

    always #5 clk = ~clk;

    // Text engine: 1-clk latency ROM, optionally salted per run.
    always @(posedge clk) pif.pixel_data <= pif.pixel_address[7:0] ^ salt;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    bit [7:0] rx[$];
    bit [7:0] frm[$];
    bit [7:0] sh;
    int bit_cnt, n_start, n_stop, n_fd, gap_cnt, last_gap, gap_bad;
    bit gap_run, prev_scl, prev_sda, cur_scl, cur_sda;
    bit first_fall_seen, first_fall_scl, nack_addr;
    logic [9:0] addr_at_start;

    initial begin
        n_start = 0; n_stop = 0; n_fd = 0; gap_bad = 0; last_gap = -1;
        first_fall_seen = 0; first_fall_scl = 0; nack_addr = 0;
        prev_scl = 1; prev_sda = 1; gap_run = 0; bit_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                rx.delete();
                bit_cnt = 0; pull = 0; gap_run = 0; prev_scl = 1; prev_sda = 1;
            end else begin
                cur_scl = scl_o;
                cur_sda = sda_line;
                if (prev_sda && !cur_sda && !first_fall_seen) begin
                    first_fall_seen = 1;
                    first_fall_scl  = cur_scl;
                end
                if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
                    rx.delete();
                    bit_cnt = 0; pull = 0;
                    n_start++;
                    addr_at_start = pif.pixel_address;
                    if (gap_run) begin
                        last_gap = gap_cnt;
                        gap_run  = 0;
                    end
                end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
                    frm = rx;
                    n_stop++;
                end else if (!prev_scl && cur_scl) begin
                    if (bit_cnt < 8) begin
                        sh = {sh[6:0], cur_sda};
                        bit_cnt++;
                        if (bit_cnt == 8) rx.push_back(sh);
                    end else begin
                        bit_cnt = 0;
                    end
                end else if (prev_scl && !cur_scl) begin
                    pull = (bit_cnt == 8) && !(nack_addr && rx.size() == 1);
                end
                if (gap_run) begin
                    if (cur_scl && cur_sda) gap_cnt++;
                    else gap_bad++;
                end
                if (frame_done) begin
                    n_fd++;
                    gap_run = 1;
                    gap_cnt = 0;
                end
                prev_scl = cur_scl;
                prev_sda = cur_sda;
            end
        end
    end

    function automatic logic [7:0] exp_byte(input int i);
        logic [7:0] a;
        if (i == 0) return 8'h78;
        if (i == 1) return 8'h40;
        a = 8'(i - 2);
        return a ^ salt;
    endfunction

    task automatic check_frame(input string tag);
        chk({tag, "_len"}, frm.size(), NB + 2);
        for (int i = 0; i < frm.size() && i < NB + 2; i++) begin
            chk({tag, "_byte"}, frm[i], exp_byte(i));
        end
    endtask

    task automatic wait_stops(input int target);
        int n = 0;
        while (n_stop < target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n_stop < target) chk("timeout_stop", n_stop, target);
    endtask

    task automatic wait_starts(input int target);
        int n = 0;
        while (n_start < target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n_start < target) chk("timeout_start", n_start, target);
    endtask

    task automatic wait_rx(input int nbytes);
        int n = 0;
        while (rx.size() < nbytes && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (rx.size() < nbytes) chk("timeout_rx", rx.size(), nbytes);
    endtask

    initial begin
        int n;
        salt = 8'h5A;
        if ($urandom_range(1, 0) == 1) salt = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_scl", scl_o, 1);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_addr", pif.pixel_address, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_nack", nack_error, 0);
        reset = 1'b1;
        enable = 1'b1;

        wait_stops(1);
        repeat (4 * CLK_DIV) @(negedge clk);
        chk("first_fall_seen", first_fall_seen, 1);
        chk("first_fall_scl", first_fall_scl, 1);
        check_frame("f1");
        chk("f1_done_cnt", n_fd, 1);

        wait_stops(2);
        repeat (4 * CLK_DIV) @(negedge clk);
        chk("f2_start_cnt", n_start, 2);
        chk("f2_addr_at_start", addr_at_start, 0);
        chk("gap_len", last_gap, GAPQ * CLK_DIV);
        chk("gap_idle", gap_bad, 0);
        check_frame("f2");
        chk("f2_done_cnt", n_fd, 2);

        wait_starts(3);
        wait_rx(2 + 12);
        enable = 1'b0;
        wait_stops(3);
        repeat (4 * CLK_DIV) @(negedge clk);
        check_frame("f3");
        chk("f3_done_cnt", n_fd, 3);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drop_busy", busy, 0);
        repeat (100) @(negedge clk);
        chk("drop_no_restart", n_start, 3);
        chk("drop_busy_hold", busy, 0);

        enable = 1'b1;
        wait_starts(4);
        wait_rx(2 + 10);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_scl", scl_o, 1);
        chk("mid_rst_sda_oe", sda_oe, 0);
        chk("mid_rst_addr", pif.pixel_address, 0);
        chk("mid_rst_busy", busy, 0);
        reset = 1'b1;
        wait_stops(4);
        nack_addr = 1;
        repeat (4 * CLK_DIV) @(negedge clk);
        check_frame("f5");
        chk("f5_done_cnt", n_fd, 4);

        wait_stops(5);
        repeat (4 * CLK_DIV) @(negedge clk);
`ifdef OLED_ACK_CHECK_EN
        chk("nack_len", frm.size(), 1);
        if (frm.size() > 0) chk("nack_addr_byte", frm[0], 8'h78);
        chk("nack_flag", nack_error, 1);
        chk("nack_no_done", n_fd, 4);
        chk("nack_addr_reset", pif.pixel_address, 0);
        nack_addr = 0;
        wait_starts(7);
        repeat (2) @(negedge clk);
        chk("nack_clear", nack_error, 0);
`else
        check_frame("f6");
        chk("nack_ignored", nack_error, 0);
        chk("f6_done_cnt", n_fd, 5);
        nack_addr = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
